mips_mmio_timer: RTL and testbench
==================================

Name: mips_mmio_timer

Overview:
- Memory-mapped down-counting timer on the single-cycle CPU data bus. Consumes memwrite, memaddr and memwritedata. Returns memreaddata combinationally in the same cycle.
- The system-level read mux selects this block's readdata when hit=1; otherwise it selects data RAM.
- Raises a level interrupt on expiry. Polled software uses the STATUS flag instead.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, word-aligned base of the 32-byte register window; compared on memaddr[31:5].
- PRESCALE_W, 16, width of the prescaler reload register and counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; reset=0 clears all state immediately.
- memwrite  input  1  CPU store strobe; acts only when hit=1.
- memaddr  input  32  CPU data address.
- memwritedata  input  32  CPU store data.
- hit  output  1  combinational; 1 when memaddr[31:5]==BASE_ADDR[31:5].
- readdata  output  32  combinational register read, 0 when hit=0.
- irq  output  1  registered; equals STATUS.expired & CTRL.ie.

Behaviour:
- Register map (offset = memaddr[4:2]):
  - 0 CTRL[2:0]: bit0 en, bit1 autoreload, bit2 ie.
  - 1 LOAD[31:0].
  - 2 COUNT[31:0]: write sets the count directly.
  - 3 STATUS[0]: expired flag; write 1 to clear.
  - 4 PRESCALE[PRESCALE_W-1:0].
  - Offsets 5-7 read 0; writes to them are ignored.
  - Unused register bits read 0.
- memaddr[1:0] is ignored. Only full-word access is supported.
- Writes take effect at the clock edge when memwrite=1 and hit=1. Reads are pure combinational decode of the current register values.
- Reset values: every register is 0, prescaler counter is 0, irq=0, FSM=STOPPED.
- Prescaler:
  - While en=1, pcnt increments each cycle.
  - When pcnt==PRESCALE, tick=1 for that cycle and pcnt wraps to 0.
  - PRESCALE=0 therefore gives a tick every cycle.
  - While en=0, pcnt is held at 0.
- FSM states:
  - STOPPED: en=0. No ticks.
  - RUNNING: en=1 and COUNT!=0.
  - DONE: en=1 and COUNT==0, one-shot finished. Ticks are ignored and COUNT holds 0.
- FSM transitions:
  - Writing CTRL.en=1 from STOPPED goes to RUNNING if COUNT!=0, otherwise to DONE. pcnt restarts at 0.
  - Writing en=0 from any state goes to STOPPED. COUNT is kept.
  - Writing COUNT to a nonzero value while in DONE goes to RUNNING.
- Tick in RUNNING:
  - COUNT>1: COUNT decrements by 1.
  - COUNT==1 with autoreload=1: COUNT<=LOAD and expired<=1. Stay in RUNNING, unless LOAD==0, in which case go to DONE.
  - COUNT==1 with autoreload=0: COUNT<=0, expired<=1, go to DONE.
- Simultaneous events:
  - A COUNT write in the same cycle as a tick: the write wins and no decrement occurs.
  - A STATUS clear in the same cycle as expiry: the set wins and expired stays 1.
  - A LOAD write in the same cycle as a reload: the old LOAD value is used.
  - A CTRL write with en=1 while already enabled does not restart pcnt.
- irq updates one cycle after expired or ie changes.
- Reset asserted mid-count immediately forces all state to the reset values. Counting resumes only after software rewrites the registers.

Decomposition:
- Shared package (timer_pkg) holds:
  - register offset constants: OFF_CTRL, OFF_LOAD, OFF_COUNT, OFF_STATUS, OFF_PRESCALE;
  - CTRL bit indices;
  - FSM state encoding: 2-bit STOPPED/RUNNING/DONE.
- One sub-module, timer_prescaler: owns the pcnt register and produces tick. Inputs: clk, reset, en, prescale.
- Register file, FSM and read mux stay in the top module.

Test Plan:
- Reset: drive reset=0 mid-run with COUNT=5 -> COUNT=0, irq=0, readdata=0 at every offset, with no clock edge needed.
- One-shot: PRESCALE=0, COUNT=3, CTRL=3'b101 -> COUNT reads 2,1,0 on successive cycles; STATUS=1 on the edge where COUNT reaches 0; irq=1 one cycle later; COUNT stays 0 for 10 more cycles.
- Auto-reload: LOAD=4, COUNT=2, PRESCALE=1, CTRL=3'b011 -> decrement every 2 cycles; after 1->reload, COUNT reads 4; expired sets every 8 cycles in steady state.
- Clear vs set: write STATUS=1 in the exact cycle of expiry -> STATUS reads 1 afterwards; clearing one cycle later reads 0.
- Write/tick collision: PRESCALE=0, RUNNING with COUNT=10, write COUNT=7 -> COUNT reads 7, not 9 or 6, on the next cycle.
- Decode: memaddr=BASE_ADDR+0x20 with memwrite=1 -> hit=0, readdata=0, no register changes. BASE_ADDR+0x14 -> hit=1, readdata=0, write ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL bit positions and FSM encoding.
package timer_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic ie;
    logic autoreload;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/mips_mmio_timer_if.sv
// CPU data-bus slice seen by the timer: store strobe, address, data, decode hit
// and combinational read data.
interface mips_mmio_timer_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic        hit;
  logic [31:0] readdata;

  modport master (output memwrite, memaddr, memwritedata, input hit, readdata);
  modport slave  (input memwrite, memaddr, memwritedata, output hit, readdata);
endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler: counts 0..prescale while enabled and pulses tick on
// the terminal value; held at 0 while disabled so enabling always starts fresh.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (!en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mips_mmio_timer.sv
// Memory-mapped down-counting timer with one-shot/auto-reload modes, a sticky
// expired flag and a registered level interrupt.
module mips_mmio_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  mips_mmio_timer_if.slave   bus,
  output logic               irq
);

  ctrl_t                 ctrl;
  logic [31:0]           load;
  logic [31:0]           count;
  logic                  expired;
  logic [PRESCALE_W-1:0] prescale;
  state_t                state;

  logic       tick;
  logic [2:0] off;
  logic       wr;
  logic       count_wr;
  logic       tick_run;
  logic       unused_addr_bits;

  assign bus.hit          = (bus.memaddr[31:5] == BASE_ADDR[31:5]);
  assign off              = bus.memaddr[4:2];
  assign wr               = bus.memwrite && bus.hit;
  assign count_wr         = wr && (off == OFF_COUNT);
  // A COUNT store in the same cycle as a tick wins outright.
  assign tick_run         = tick && (state == RUNNING) && !count_wr;
  assign unused_addr_bits = ^bus.memaddr[1:0];

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl.en),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    // NOTE: default first so every path assigns readdata and no latch is inferred.
    bus.readdata = '0;
    if (bus.hit) begin
      case (off)
        OFF_CTRL:     bus.readdata = {29'd0, ctrl};
        OFF_LOAD:     bus.readdata = load;
        OFF_COUNT:    bus.readdata = count;
        OFF_STATUS:   bus.readdata = {31'd0, expired};
        OFF_PRESCALE: bus.readdata = {{(32-PRESCALE_W){1'b0}}, prescale};
        default:      bus.readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      load     <= '0;
      count    <= '0;
      expired  <= 1'b0;
      prescale <= '0;
      state    <= STOPPED;
      irq      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the register-write section below is placed
      // after the tick section so a disabling CTRL store overrides a same-cycle expiry.
      irq <= expired && ctrl.ie;

      if (tick_run) begin
        if (count > 32'd1) begin
          count <= count - 32'd1;
        end else if (ctrl.autoreload) begin
          count   <= load;
          expired <= 1'b1;
          if (load == 32'd0) state <= DONE;
        end else begin
          count   <= '0;
          expired <= 1'b1;
          state   <= DONE;
        end
      end

      if (wr) begin
        case (off)
          OFF_CTRL: begin
            ctrl <= '{ie:         bus.memwritedata[CTRL_IE],
                      autoreload: bus.memwritedata[CTRL_AR],
                      en:         bus.memwritedata[CTRL_EN]};
            if (!bus.memwritedata[CTRL_EN]) begin
              state <= STOPPED;
            end else if (state == STOPPED) begin
              state <= (count != 32'd0) ? RUNNING : DONE;
            end
          end
          OFF_LOAD: load <= bus.memwritedata;
          OFF_COUNT: begin
            count <= bus.memwritedata;
            if (state != STOPPED) begin
              state <= (bus.memwritedata != 32'd0) ? RUNNING : DONE;
            end
          end
          // Clearing loses to an expiry in the same cycle.
          OFF_STATUS: if (bus.memwritedata[0] && !tick_run) expired <= 1'b0;
          OFF_PRESCALE: prescale <= bus.memwritedata[PRESCALE_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_mmio_timer.sv
// Directed self-checking bench for mips_mmio_timer: reset, one-shot, auto-reload,
// clear/set race, write/tick collision, enable re-write and address decode.
module tb_mips_mmio_timer;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;
  int   total = 0;
  int   bad = 0;

  mips_mmio_timer_if bus ();

  mips_mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic wr_addr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.memaddr      = addr;
    bus.memwritedata = data;
    bus.memwrite     = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite     = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    wr_addr(BASE + {27'd0, off, 2'b00}, data);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] data);
    bus.memwrite = 1'b0;
    bus.memaddr  = BASE + {27'd0, off, 2'b00};
    #1;
    data = bus.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL reset_init_off%0d got=%h want=%h", i, v, 32'd0);
      end
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_init_irq got=%b want=0", irq);
    end
    @(negedge clk);
    reset = 1'b1;
    wr(OFF_LOAD, 32'd9);
    wr(OFF_PRESCALE, 32'd3);
    wr(OFF_COUNT, 32'd5);
    wr(OFF_CTRL, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_count got=%h want=%h", v, 32'd0);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_irq got=%b want=0", irq);
    end
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL reset_mid_off%0d got=%h want=%h", i, v, 32'd0);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_one_shot();
    logic [31:0] v;
    logic [31:0] s;
    wr(OFF_PRESCALE, 32'd0);
    wr(OFF_COUNT, 32'd3);
    wr(OFF_CTRL, 32'd5);
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd3) begin
      bad++;
      $display("FAIL oneshot_start got=%h want=%h", v, 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rd(OFF_COUNT, v);
      rd(OFF_STATUS, s);
      total++;
      if (v !== 32'(2 - i)) begin
        bad++;
        $display("FAIL oneshot_count%0d got=%h want=%h", i, v, 32'(2 - i));
      end
      total++;
      if (s !== ((i == 2) ? 32'd1 : 32'd0)) begin
        bad++;
        $display("FAIL oneshot_status%0d got=%h want=%h", i, s, (i == 2) ? 32'd1 : 32'd0);
      end
      total++;
      if (irq !== 1'b0) begin
        bad++;
        $display("FAIL oneshot_irq_early%0d got=%b want=0", i, irq);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_irq got=%b want=1", irq);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      rd(OFF_COUNT, v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL oneshot_hold%0d got=%h want=%h", i, v, 32'd0);
      end
    end
    wr(OFF_COUNT, 32'd2);
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd2) begin
      bad++;
      $display("FAIL done_rewrite got=%h want=%h", v, 32'd2);
    end
    @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd1) begin
      bad++;
      $display("FAIL done_restart got=%h want=%h", v, 32'd1);
    end
    wr(OFF_CTRL, 32'd0);
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, s);
    total++;
    if (s !== 32'd0) begin
      bad++;
      $display("FAIL oneshot_clear got=%h want=%h", s, 32'd0);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_irq_off got=%b want=0", irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic [31:0] s;
    logic [31:0] exp_count [12] = '{32'd2, 32'd1, 32'd1, 32'd4, 32'd4, 32'd3,
                                    32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd4};
    wr(OFF_LOAD, 32'd4);
    wr(OFF_PRESCALE, 32'd1);
    wr(OFF_COUNT, 32'd2);
    wr(OFF_CTRL, 32'd3);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      rd(OFF_COUNT, v);
      rd(OFF_STATUS, s);
      total++;
      if (v !== exp_count[k]) begin
        bad++;
        $display("FAIL reload_count%0d got=%h want=%h", k + 1, v, exp_count[k]);
      end
      total++;
      if (s !== ((k >= 3) ? 32'd1 : 32'd0)) begin
        bad++;
        $display("FAIL reload_status%0d got=%h want=%h", k + 1, s, (k >= 3) ? 32'd1 : 32'd0);
      end
    end
    wr(OFF_CTRL, 32'd0);
    wr(OFF_STATUS, 32'd1);
  endtask

  task automatic test_clear_vs_set();
    logic [31:0] v;
    wr(OFF_PRESCALE, 32'd0);
    wr(OFF_COUNT, 32'd2);
    wr(OFF_CTRL, 32'd1);
    @(posedge clk);
    wr(OFF_STATUS, 32'd1);
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL race_count got=%h want=%h", v, 32'd0);
    end
    rd(OFF_STATUS, v);
    total++;
    if (v !== 32'd1) begin
      bad++;
      $display("FAIL race_set_wins got=%h want=%h", v, 32'd1);
    end
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL race_late_clear got=%h want=%h", v, 32'd0);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL race_irq_masked got=%b want=0", irq);
    end
    wr(OFF_CTRL, 32'd0);
  endtask

  task automatic test_collision();
    logic [31:0] v;
    wr(OFF_PRESCALE, 32'd0);
    wr(OFF_COUNT, 32'd10);
    wr(OFF_CTRL, 32'd1);
    wr(OFF_COUNT, 32'd7);
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd7) begin
      bad++;
      $display("FAIL collide_write_wins got=%h want=%h", v, 32'd7);
    end
    @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd6) begin
      bad++;
      $display("FAIL collide_next got=%h want=%h", v, 32'd6);
    end
    wr(OFF_CTRL, 32'd0);
  endtask

  task automatic test_enable_rewrite();
    logic [31:0] v;
    wr(OFF_PRESCALE, 32'd3);
    wr(OFF_COUNT, 32'd10);
    wr(OFF_CTRL, 32'd1);
    @(posedge clk);
    @(posedge clk);
    wr(OFF_CTRL, 32'd1);
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd10) begin
      bad++;
      $display("FAIL rewrite_before got=%h want=%h", v, 32'd10);
    end
    @(posedge clk);
    #1;
    rd(OFF_COUNT, v);
    total++;
    if (v !== 32'd9) begin
      bad++;
      $display("FAIL rewrite_no_restart got=%h want=%h", v, 32'd9);
    end
    wr(OFF_CTRL, 32'd0);
  endtask

  task automatic test_decode();
    logic [31:0] v;
    logic [31:0] addrs [3] = '{BASE + 32'h20, BASE + 32'h14, BASE - 32'h4};
    logic        hits  [3] = '{1'b0, 1'b1, 1'b0};
    wr(OFF_LOAD, 32'h1234_5678);
    bus.memaddr = BASE + 32'h7;
    #1;
    total++;
    if (bus.readdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL decode_low_bits got=%h want=%h", bus.readdata, 32'h1234_5678);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.memaddr      = addrs[i];
      bus.memwritedata = 32'hFFFF_FFFF;
      bus.memwrite     = 1'b1;
      #1;
      total++;
      if (bus.hit !== hits[i]) begin
        bad++;
        $display("FAIL decode_hit%0d got=%b want=%b", i, bus.hit, hits[i]);
      end
      total++;
      if (bus.readdata !== 32'd0) begin
        bad++;
        $display("FAIL decode_rdata%0d got=%h want=%h", i, bus.readdata, 32'd0);
      end
      @(posedge clk);
      #1;
      bus.memwrite = 1'b0;
      rd(OFF_CTRL, v);
      total++;
      if (v !== 32'd0) begin
        bad++;
        $display("FAIL decode_ctrl%0d got=%h want=%h", i, v, 32'd0);
      end
      rd(OFF_LOAD, v);
      total++;
      if (v !== 32'h1234_5678) begin
        bad++;
        $display("FAIL decode_load%0d got=%h want=%h", i, v, 32'h1234_5678);
      end
    end
  endtask

  initial begin
    bus.memwrite     = 1'b0;
    bus.memaddr      = '0;
    bus.memwritedata = '0;
    test_reset();
    test_one_shot();
    test_autoreload();
    test_clear_vs_set();
    test_collision();
    test_enable_rewrite();
    test_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
